flash_arb: RTL



---
 rtl/flash_arb_pkg.sv | 22 ++
 rtl/flash_arb_if.sv | 28 ++
 rtl/flash_arb.sv | 127 ++++++++++++
 3 files changed

// File: rtl/flash_arb_pkg.sv
// Shared types for the SPI flash byte-stream arbiter: FSM states, the
// per-requester transfer bundle and the default end-of-transaction format.
package flash_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OWN,
        DRAIN,
        CLOSE,
        GAP
    } state_t;

    localparam logic [2:0] END_FMT_DEFAULT = 3'd0;

    typedef struct packed {
        logic       wr;
        logic [7:0] dout;
        logic [2:0] format;
        logic [3:0] rate;
    } xfer_t;

endpackage

// File: rtl/flash_arb_if.sv
// Byte-stream port bundles: flash_req_if is one requester's link to the
// arbiter, flash_dev_if is the arbiter's link to sflash.
interface flash_req_if;
    logic       req;
    logic       gnt;
    logic       wr;
    logic [7:0] dout;
    logic [2:0] format;
    logic [3:0] rate;
    logic       ready;
    logic [7:0] din;

    modport master (output req, wr, dout, format, rate, input gnt, ready, din);
    modport slave  (input req, wr, dout, format, rate, output gnt, ready, din);
endinterface

interface flash_dev_if;
    logic       ready;
    logic       wr;
    logic       who;
    logic [7:0] dout;
    logic [2:0] format;
    logic [3:0] rate;
    logic [7:0] din;

    modport master (input ready, din, output wr, who, dout, format, rate);
    modport slave  (output ready, din, input wr, who, dout, format, rate);
endinterface

// File: rtl/flash_arb.sv
// Two-requester SPI flash arbiter: whole-transaction ownership, CLOSE strobe
// on release, inter-transaction gap and an idle-owner timeout with lockout.
module flash_arb
    import flash_arb_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TO_BITS    = 12,
    parameter logic [2:0]  END_FMT    = END_FMT_DEFAULT
) (
    input  logic        clk,
    input  logic        arstn,
    flash_req_if.slave  r0,
    flash_req_if.slave  r1,
    flash_dev_if.master f,
    output logic [1:0]  to_err,
    input  logic        err_clr
);

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TO_BITS-1:0] TO_ALMOST = ~TO_BITS'(1);

    function automatic xfer_t pick(input logic sel, input xfer_t a, input xfer_t b);
        return sel ? b : a;
    endfunction

    state_t             state, state_nxt;
    logic               owner, last, win, grant;
    logic [1:0]         blocked, req_vec, elig, gnt_vec, set_err;
    logic [TO_BITS-1:0] to_cnt;
    logic [GW-1:0]      gap_cnt;
    logic [3:0]         rate_q;
    logic               own_req, own_wr, idle_inc, to_fire;
    xfer_t              x0, x1, xo;

    assign x0 = '{wr: r0.wr, dout: r0.dout, format: r0.format, rate: r0.rate};
    assign x1 = '{wr: r1.wr, dout: r1.dout, format: r1.format, rate: r1.rate};
    assign xo = pick(owner, x0, x1);

    assign req_vec  = {r1.req, r0.req};
    assign elig     = req_vec & ~blocked;
    assign own_req  = owner ? r1.req : r0.req;
    assign own_wr   = (state == OWN) && xo.wr;
    assign idle_inc = (state == OWN) && f.ready && !xo.wr;
    // A released owner is a normal release even if its counter is about to expire.
    assign to_fire  = idle_inc && own_req && (to_cnt == TO_ALMOST);
    assign set_err  = to_fire ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign gnt_vec  = (state == OWN) ? (owner ? 2'b10 : 2'b01) : 2'b00;

    assign r0.gnt   = gnt_vec[0];
    assign r1.gnt   = gnt_vec[1];
    assign r0.ready = f.ready && gnt_vec[0];
    assign r1.ready = f.ready && gnt_vec[1];
    assign r0.din   = f.din;
    assign r1.din   = f.din;
    assign f.who    = owner;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        win       = owner;
        unique case (state)
            IDLE: begin
                if (elig != 2'b00) begin
                    grant     = 1'b1;
                    win       = (elig == 2'b11) ? ~last : elig[1];
                    state_nxt = OWN;
                end
            end
            OWN: begin
                if (!own_req || to_fire) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (f.ready) state_nxt = CLOSE;
            end
            CLOSE: state_nxt = GAP;
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        f.wr     = 1'b0;
        f.dout   = '0;
        f.format = END_FMT;
        f.rate   = rate_q;
        unique case (state)
            OWN: begin
                f.wr     = xo.wr;
                f.dout   = xo.dout;
                f.format = xo.format;
                f.rate   = xo.rate;
            end
            CLOSE: f.wr = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state   <= IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            blocked <= '0;
            to_err  <= '0;
            to_cnt  <= '0;
            gap_cnt <= '0;
            rate_q  <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner <= win;
                last  <= win;
            end
            if (grant || own_wr)
                to_cnt <= '0;
            else if (idle_inc && to_cnt != '1)
                to_cnt <= to_cnt + TO_BITS'(1);
            gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
            if (state == OWN) rate_q <= xo.rate;
            blocked <= (blocked & req_vec) | set_err;
            to_err  <= (err_clr ? 2'b00 : to_err) | set_err;
        end
    end

endmodule
